uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one UART transmitter (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 256, giving the i_TICK count after o_TX_START at which a frame is abandoned.
REQ-003 The block SHALL have parameter GAP_TICKS, default 16, giving the idle i_TICK count enforced between frames.
REQ-004 The block SHALL have ports:
 P_CLK  input  1  system clock, all logic on rising edge.
 reset  input  1  asynchronous, active-high reset.
 i_TICK  input  1  16x-oversample baud tick, one P_CLK wide.
 i_REQ  input  NUM_REQ  per-requester frame request, level.
 i_DATA  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
 o_ACK  output  NUM_REQ  one-hot one-cycle pulse: frame for that requester finished.
 o_TX_DATA  output  8  byte to transmitter.
 o_TX_DV  output  1  one-cycle data-load strobe to transmitter.
 o_TX_START  output  1  one-cycle start strobe to transmitter.
 i_TX_DONE  input  1  transmitter frame-complete indication.
 o_BUSY  output  1  high in every state except IDLE.
 o_OWNER  output  clog2(NUM_REQ)  index of current/last granted requester.
 o_TIMEOUT  output  1  one-cycle pulse when a frame is abandoned.

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, START, WAIT, GAP.
REQ-006 IDLE: if any i_REQ bit high, SHALL select requester by round-robin starting at (last_owner+1) mod NUM_REQ, register its byte into o_TX_DATA, assert o_TX_DV for that one cycle, set o_OWNER, go LOAD.
REQ-007 LOAD: SHALL hold o_TX_DATA, deassert o_TX_DV, go START after one cycle.
REQ-008 START: SHALL assert o_TX_START for exactly one cycle, clear tick counter, go WAIT.
REQ-009 WAIT: SHALL increment a tick counter on each i_TICK; on i_TX_DONE high SHALL pulse o_ACK[o_OWNER], update last_owner, clear counter, go GAP.
REQ-010 WAIT: if counter reaches TIMEOUT_TICKS before i_TX_DONE, SHALL pulse o_TIMEOUT and o_ACK[o_OWNER] in the same cycle, update last_owner, go GAP.
REQ-011 i_TX_DONE and timeout in same cycle: completion SHALL win, o_TIMEOUT stays low.
REQ-012 i_TX_DONE SHALL be ignored outside WAIT (stale level from previous frame has no effect).
REQ-013 GAP: SHALL count GAP_TICKS i_TICK pulses then go IDLE; i_REQ not sampled in GAP.
REQ-014 Requester SHALL hold i_REQ and i_DATA stable until its o_ACK; byte is captured only in IDLE, later i_DATA changes have no effect on the frame in flight.
REQ-015 i_REQ dropped after grant but before o_ACK SHALL NOT abort the frame; o_ACK still pulses.
REQ-016 i_REQ still high in IDLE after o_ACK SHALL be treated as a new request, at lowest priority under round-robin.
REQ-017 Tick counter SHALL be wide enough for TIMEOUT_TICKS and SHALL saturate, never wrap.
REQ-018 At most one o_ACK bit SHALL be high per cycle; o_TX_DV and o_TX_START SHALL never be high in the same cycle.
REQ-019 Latency: grant to o_TX_START SHALL be exactly 2 P_CLK cycles.

Reset
REQ-020 On reset high, asynchronously: state IDLE, o_TX_DATA 0, o_TX_DV 0, o_TX_START 0, o_ACK 0, o_BUSY 0, o_TIMEOUT 0, o_OWNER 0, counters 0, last_owner NUM_REQ-1 (requester 0 highest priority first).
REQ-021 Reset mid-frame SHALL abandon the frame with no o_ACK; the requester re-requests after release.
REQ-022 First grant SHALL be possible on the first P_CLK edge after reset deasserts.

Verification
REQ-023 Single request: i_REQ=0001, data 0xA5 -> o_TX_DV with o_TX_DATA=0xA5, o_TX_START 2 cycles later, o_ACK=0001 on i_TX_DONE, o_BUSY low after 16 GAP ticks.
REQ-024 Contention: i_REQ=1111 held, each dropped on its ACK -> grant order 0,1,2,3; ACK order same; one GAP between frames.
REQ-025 Fairness: requester 0 re-asserts immediately after ACK while 2 pending -> 2 served before 0 again.
REQ-026 Timeout: i_TX_DONE never asserted -> o_TIMEOUT and o_ACK pulse at tick 256 after START; next requester served.
REQ-027 Done/timeout collision: i_TX_DONE on the 256th tick cycle -> o_ACK only, o_TIMEOUT low.
REQ-028 Reset in WAIT -> all outputs to REQ-020 values, no o_ACK; pending i_REQ=0100 re-granted to requester 2 after release.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ requesters. Requests are
//   served round-robin. Each grant loads the requester's byte, strobes the
//   transmitter start, and waits for frame completion or a tick timeout. It
//   then enforces an idle gap of GAP_TICKS baud ticks before the next grant.
//
// Ports
//   P_CLK       system clock, rising edge
//   reset       asynchronous active-high reset
//   i_TICK      16x-oversample baud tick, one P_CLK wide
//   i_REQ       per-requester request level
//   i_DATA      per-requester byte, requester k on [8k+7:8k]
//   o_ACK       one-hot, one-cycle pulse when a requester's frame ends
//   o_TX_DATA   byte presented to the transmitter
//   o_TX_DV     one-cycle data-load strobe
//   o_TX_START  one-cycle transmit start strobe
//   i_TX_DONE   transmitter frame-complete indication
//   o_BUSY      high whenever the FSM is not idle
//   o_OWNER     index of the current or last granted requester
//   o_TIMEOUT   one-cycle pulse when a frame is abandoned
//
// State | meaning
// IDLE  | waiting for any request; grants round-robin and loads the byte
// LOAD  | byte held on o_TX_DATA, load strobe already issued
// START | issues the one-cycle start strobe, clears the tick counter
// WAIT  | counts ticks until i_TX_DONE or timeout, then acknowledges
// GAP   | enforces GAP_TICKS idle ticks before the next grant

module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_TICKS = 256,
  parameter int GAP_TICKS     = 16
) (
  input  logic                       P_CLK,
  input  logic                       reset,
  input  logic                       i_TICK,
  input  logic [NUM_REQ-1:0]         i_REQ,
  input  logic [8*NUM_REQ-1:0]       i_DATA,
  output logic [NUM_REQ-1:0]         o_ACK,
  output logic [7:0]                 o_TX_DATA,
  output logic                       o_TX_DV,
  output logic                       o_TX_START,
  input  logic                       i_TX_DONE,
  output logic                       o_BUSY,
  output logic [$clog2(NUM_REQ)-1:0] o_OWNER,
  output logic                       o_TIMEOUT
);

  localparam int OW       = $clog2(NUM_REQ);
  // One counter serves both WAIT and GAP, so it is sized for the larger limit.
  localparam int CNT_MAXV = (TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS;
  localparam int CW       = $clog2(CNT_MAXV + 1);

  localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAXV);
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT_TICKS);
  localparam logic [CW-1:0] GAP_VAL = CW'(GAP_TICKS);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP} state_t;

  state_t              state, state_n;
  logic [7:0]          tx_data_n;
  logic                tx_dv_n, tx_start_n, timeout_n;
  logic [NUM_REQ-1:0]  ack_n, owner_onehot;
  logic [OW-1:0]       owner_n, last_owner, last_n;
  logic [CW-1:0]       cnt, cnt_n, cnt_tick;
  logic [OW-1:0]       grant_idx, cand;
  logic                grant_found;
  logic [7:0]          req_data [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_data
    assign req_data[k] = i_DATA[8*k +: 8];
  end

  assign o_BUSY       = (state != IDLE);
  assign owner_onehot = NUM_REQ'(1) << o_OWNER;

  // Saturating increment: a stuck-high tick stream can never wrap the count
  // back under the timeout limit.
  assign cnt_tick = (i_TICK && (cnt != CNT_SAT)) ? cnt + 1'b1 : cnt;

  // Round-robin search starting just after the last acknowledged requester,
  // so a requester that keeps its request high drops to lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = OW'((int'(last_owner) + 1 + i) % NUM_REQ);
      if (!grant_found && i_REQ[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    tx_data_n  = o_TX_DATA;
    tx_dv_n    = 1'b0;
    tx_start_n = 1'b0;
    ack_n      = '0;
    timeout_n  = 1'b0;
    owner_n    = o_OWNER;
    last_n     = last_owner;
    cnt_n      = cnt;
    unique case (state)
      IDLE: begin
        if (grant_found) begin
          tx_data_n = req_data[grant_idx];
          tx_dv_n   = 1'b1;
          owner_n   = grant_idx;
          state_n   = LOAD;
        end
      end
      LOAD: state_n = START;
      START: begin
        tx_start_n = 1'b1;
        cnt_n      = '0;
        state_n    = WAIT;
      end
      WAIT: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (i_TX_DONE) begin
          ack_n   = owner_onehot;
          last_n  = o_OWNER;
          cnt_n   = '0;
          state_n = GAP;
        end else if (cnt_tick >= TO_VAL) begin
          timeout_n = 1'b1;
          ack_n     = owner_onehot;
          last_n    = o_OWNER;
          cnt_n     = '0;
          state_n   = GAP;
        end else begin
          cnt_n = cnt_tick;
        end
      end
      GAP: begin
        if (cnt_tick >= GAP_VAL) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_tick;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      o_TX_DATA  <= '0;
      o_TX_DV    <= 1'b0;
      o_TX_START <= 1'b0;
      o_ACK      <= '0;
      o_TIMEOUT  <= 1'b0;
      o_OWNER    <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      cnt        <= '0;
    end else begin
      state      <= state_n;
      o_TX_DATA  <= tx_data_n;
      o_TX_DV    <= tx_dv_n;
      o_TX_START <= tx_start_n;
      o_ACK      <= ack_n;
      o_TIMEOUT  <= timeout_n;
      o_OWNER    <= owner_n;
      last_owner <= last_n;
      cnt        <= cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter. The stimulus pushes expected grants
//   and acknowledges into queues. A monitor sampling just after each rising
//   edge pops them and compares. A small transmitter model raises
//   i_TX_DONE a set number of ticks after each start strobe and holds it
//   until the next start.

module tb_uart_tx_arbiter;

  localparam int NR       = 4;
  localparam int TO       = 256;
  localparam int GAP      = 16;
  localparam int TICK_DIV = 3;

  logic            P_CLK = 1'b0;
  logic            reset;
  logic            i_TICK;
  logic [NR-1:0]   i_REQ;
  logic [8*NR-1:0] i_DATA;
  logic [NR-1:0]   o_ACK;
  logic [7:0]      o_TX_DATA;
  logic            o_TX_DV;
  logic            o_TX_START;
  logic            i_TX_DONE;
  logic            o_BUSY;
  logic [1:0]      o_OWNER;
  logic            o_TIMEOUT;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_TICKS(TO), .GAP_TICKS(GAP)) dut (
    .P_CLK(P_CLK), .reset(reset), .i_TICK(i_TICK), .i_REQ(i_REQ), .i_DATA(i_DATA),
    .o_ACK(o_ACK), .o_TX_DATA(o_TX_DATA), .o_TX_DV(o_TX_DV), .o_TX_START(o_TX_START),
    .i_TX_DONE(i_TX_DONE), .o_BUSY(o_BUSY), .o_OWNER(o_OWNER), .o_TIMEOUT(o_TIMEOUT)
  );

  always #5 P_CLK = ~P_CLK;

  typedef struct { logic [1:0] owner; logic [7:0] data; } grant_t;
  typedef struct { logic [NR-1:0] ack; logic to; int ticks; } ack_t;

  grant_t grant_q[$];
  ack_t   ack_q[$];
  int     checks = 0;
  int     errors = 0;

  logic [7:0] base_data [NR] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
  logic [7:0] dat [NR];
  int         ticks_for [NR];
  int         want_acks [NR];
  int         served [NR];
  int         tick_div = 0;
  int         tx_cnt = 0;
  int         tx_len = 0;
  bit         tx_active = 0;

  always_comb i_DATA = {dat[3], dat[2], dat[1], dat[0]};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  task automatic push_grant(input logic [1:0] o, input logic [7:0] d);
    grant_t g;
    g.owner = o;
    g.data  = d;
    grant_q.push_back(g);
  endtask

  task automatic push_ack(input logic [NR-1:0] a, input logic to, input int t);
    ack_t r;
    r.ack   = a;
    r.to    = to;
    r.ticks = t;
    ack_q.push_back(r);
  endtask

  // Advance to the next falling edge, drive the tick and the transmitter model.
  task automatic step();
    @(negedge P_CLK);
    tick_div = (tick_div + 1) % TICK_DIV;
    i_TICK   = (tick_div == 0);
    if (o_TX_START) begin
      tx_active = 1;
      tx_cnt    = 0;
      tx_len    = ticks_for[o_OWNER];
      i_TX_DONE = 1'b0;
    end
    if (tx_active && tx_len > 0) begin
      if (i_TICK) tx_cnt++;
      if (tx_cnt >= tx_len) begin
        i_TX_DONE = 1'b1;
        tx_active = 0;
      end
    end
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    while (o_ACK == '0 && n < budget) begin
      step();
      n++;
    end
    check("ack_wait_budget", 32'(n < budget), 1);
  endtask

  // Hold the given requests; scramble a granted byte until its ACK; drop each
  // requester after want_acks acknowledges, or right at grant if drop_g is set.
  task automatic run_traffic(input logic [NR-1:0] req, input logic [NR-1:0] drop_g, input int budget);
    int n;
    n = 0;
    served = '{default: 0};
    i_REQ = req;
    do begin
      step();
      n++;
      if (o_TX_DV) begin
        dat[o_OWNER] = ~base_data[o_OWNER];
        if (drop_g[o_OWNER]) i_REQ[o_OWNER] = 1'b0;
      end
      for (logic [2:0] kk = 3'd0; kk < 3'd4; kk++) begin
        if (o_ACK[kk[1:0]]) begin
          dat[kk[1:0]] = base_data[kk[1:0]];
          served[kk[1:0]]++;
          if (served[kk[1:0]] >= want_acks[kk[1:0]]) i_REQ[kk[1:0]] = 1'b0;
        end
      end
    end while ((i_REQ != '0 || o_BUSY) && n < budget);
    check("traffic_budget", 32'(n < budget), 1);
  endtask

  initial begin : monitor
    grant_t g;
    ack_t   a;
    int     wait_ticks;
    int     gap_ticks;
    int     dv_age;
    bit     in_wait;
    wait_ticks = 0;
    gap_ticks  = 1000;
    dv_age     = -1;
    in_wait    = 0;
    forever begin
      @(posedge P_CLK);
      #1;
      if (reset) begin
        in_wait   = 0;
        dv_age    = -1;
        gap_ticks = 1000;
      end else begin
        if (in_wait && i_TICK) wait_ticks++;
        if (dv_age >= 0) dv_age++;
        if (o_TX_DV || o_TX_START) check("dv_start_exclusive", 32'(o_TX_DV & o_TX_START), 0);
        if (o_TX_DV) begin
          if (grant_q.size() == 0) begin
            check("grant_unexpected", 32'(o_TX_DV), 0);
          end else begin
            g = grant_q.pop_front();
            check("grant_owner", 32'(o_OWNER), 32'(g.owner));
            check("grant_data", 32'(o_TX_DATA), 32'(g.data));
            check("gap_before_grant", 32'(gap_ticks >= GAP), 1);
          end
          dv_age = 0;
        end
        if (i_TICK) gap_ticks++;
        if (o_TX_START) begin
          check("start_latency", 32'(dv_age), 2);
          dv_age     = -1;
          in_wait    = 1;
          wait_ticks = 0;
        end else if (dv_age == 3) begin
          check("start_missing", 32'(o_TX_START), 1);
          dv_age = -1;
        end
        if (o_ACK != '0 || o_TIMEOUT) begin
          if (ack_q.size() == 0) begin
            check("ack_unexpected", 32'({o_TIMEOUT, o_ACK}), 0);
          end else begin
            a = ack_q.pop_front();
            check("ack_vector", 32'(o_ACK), 32'(a.ack));
            check("timeout_flag", 32'(o_TIMEOUT), 32'(a.to));
            check("ack_tick_count", 32'(wait_ticks), 32'(a.ticks));
          end
          in_wait   = 0;
          gap_ticks = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c;
    int n;
    reset     = 1'b1;
    i_TICK    = 1'b0;
    i_TX_DONE = 1'b0;
    i_REQ     = '0;
    dat       = base_data;
    ticks_for = '{160, 160, 160, 160};
    want_acks = '{1, 1, 1, 1};
    step();
    step();
    check("rst_tx_dv", 32'(o_TX_DV), 0);
    check("rst_tx_start", 32'(o_TX_START), 0);
    check("rst_ack", 32'(o_ACK), 0);
    check("rst_busy", 32'(o_BUSY), 0);
    check("rst_timeout", 32'(o_TIMEOUT), 0);
    check("rst_owner", 32'(o_OWNER), 0);
    check("rst_tx_data", 32'(o_TX_DATA), 0);

    // Single request, granted on the first edge after reset release.
    i_REQ = 4'b0001;
    push_grant(2'd0, 8'hA5);
    push_ack(4'b0001, 1'b0, 160);
    step();
    reset = 1'b0;
    @(posedge P_CLK);
    #1;
    check("first_grant_dv", 32'(o_TX_DV), 1);
    wait_ack(2000);
    i_REQ = '0;
    c = i_TICK ? 1 : 0;
    n = 0;
    while (c < GAP && n < 200) begin
      step();
      n++;
      if (i_TICK) c++;
    end
    check("busy_last_gap_tick", 32'(o_BUSY), 1);
    step();
    check("busy_after_gap", 32'(o_BUSY), 0);

    // Contention from reset: order 0,1,2,3.
    do_reset();
    for (logic [2:0] kk = 3'd0; kk < 3'd4; kk++) begin
      push_grant(kk[1:0], base_data[kk[1:0]]);
      push_ack(NR'(1) << kk[1:0], 1'b0, 160);
    end
    run_traffic(4'b1111, 4'b0000, 8000);

    // Fairness: requester 0 keeps requesting, 2 goes in between.
    ticks_for = '{40, 40, 40, 40};
    want_acks = '{2, 1, 1, 1};
    push_grant(2'd0, 8'hA5); push_ack(4'b0001, 1'b0, 40);
    push_grant(2'd2, 8'h5A); push_ack(4'b0100, 1'b0, 40);
    push_grant(2'd0, 8'hA5); push_ack(4'b0001, 1'b0, 40);
    run_traffic(4'b0101, 4'b0000, 4000);

    // Timeout on requester 1 (request dropped at grant), then 0 is served.
    ticks_for = '{40, 0, 40, 40};
    want_acks = '{1, 1, 1, 1};
    push_grant(2'd1, 8'h3C); push_ack(4'b0010, 1'b1, TO);
    push_grant(2'd0, 8'hA5); push_ack(4'b0001, 1'b0, 40);
    run_traffic(4'b0011, 4'b0010, 4000);

    // Done arrives on the very tick that would time out.
    ticks_for[2] = TO;
    push_grant(2'd2, 8'h5A); push_ack(4'b0100, 1'b0, TO);
    run_traffic(4'b0100, 4'b0000, 4000);

    // Reset while waiting; requester 2 is re-granted after release.
    ticks_for[2] = 0;
    push_grant(2'd2, 8'h5A);
    i_REQ = 4'b0100;
    n = 0;
    while (!o_TX_START && n < 50) begin
      step();
      n++;
    end
    check("reset_test_start_seen", 32'(o_TX_START), 1);
    repeat (30) step();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_tx_dv", 32'(o_TX_DV), 0);
    check("midrst_ack", 32'(o_ACK), 0);
    check("midrst_busy", 32'(o_BUSY), 0);
    check("midrst_timeout", 32'(o_TIMEOUT), 0);
    check("midrst_owner", 32'(o_OWNER), 0);
    check("midrst_tx_data", 32'(o_TX_DATA), 0);
    repeat (3) step();
    ticks_for[2] = 60;
    push_grant(2'd2, 8'h5A);
    push_ack(4'b0100, 1'b0, 60);
    reset = 1'b0;
    @(posedge P_CLK);
    #1;
    check("regrant_dv", 32'(o_TX_DV), 1);
    check("regrant_owner", 32'(o_OWNER), 2);
    wait_ack(2000);
    i_REQ = '0;
    n = 0;
    while (o_BUSY && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
    check("grant_queue_drained", 32'(grant_q.size()), 0);
    check("ack_queue_drained", 32'(ack_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
